// File: rtl/apb_mux_tmo_if.sv
// Bus bundle for apb_mux_tmo: the APB master side plus the fan-out to SLAVES peripherals.
// 'master' is the environment view (bridge and peripherals); 'slave' is the mux's own view.
interface apb_mux_tmo_if #(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 8,
  parameter int SLAVES     = 8
);
  logic                                 MST_PSEL;
  logic                                 MST_PENABLE;
  logic [PADDR_SIZE-1:0]                MST_PADDR;
  logic [PDATA_SIZE-1:0]                MST_PRDATA;
  logic                                 MST_PREADY;
  logic                                 MST_PSLVERR;

  logic [SLAVES-1:0]                    SLV_PSEL;
  logic [SLAVES-1:0][PDATA_SIZE-1:0]    SLV_PRDATA;
  logic [SLAVES-1:0]                    SLV_PREADY;
  logic [SLAVES-1:0]                    SLV_PSLVERR;

  modport master (
    output MST_PSEL, MST_PENABLE, MST_PADDR,
    output SLV_PRDATA, SLV_PREADY, SLV_PSLVERR,
    input  MST_PRDATA, MST_PREADY, MST_PSLVERR,
    input  SLV_PSEL
  );

  modport slave (
    input  MST_PSEL, MST_PENABLE, MST_PADDR,
    input  SLV_PRDATA, SLV_PREADY, SLV_PSLVERR,
    output MST_PRDATA, MST_PREADY, MST_PSLVERR,
    output SLV_PSEL
  );
endinterface

// File: rtl/apb_mux_tmo.sv
// APB4 address decoder / read-data multiplexer with a default error slave for unmapped
// addresses and an access-phase watchdog that aborts transfers to unresponsive slaves.
module apb_mux_tmo #(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 8,
  parameter int SLAVES     = 8,
  parameter int TIMEOUT    = 16,
  localparam int SLV_W     = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                                PCLK,
  input  logic                                PRESET,
  apb_mux_tmo_if.slave                        bus,
  input  logic [SLAVES-1:0][PADDR_SIZE-1:0]   slv_addr,
  input  logic [SLAVES-1:0][PADDR_SIZE-1:0]   slv_mask,
  output logic                                err_unmapped,
  output logic                                err_timeout,
  output logic [SLV_W-1:0]                    err_slv
);

  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN   = (TIMEOUT > 0);
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACC     = 2'd1;
  localparam logic [1:0] ST_ACC_DEF = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [SLV_W-1:0]  idx;

  logic              setup;
  logic              hit;
  logic [SLV_W-1:0]  hit_idx;
  logic              tmo_last;
  logic              timeout_hit;

  logic [SLAVES-1:0]     psel;
  logic [PDATA_SIZE-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  assign setup    = bus.MST_PSEL & ~bus.MST_PENABLE;
  assign tmo_last = TMO_EN && (cnt == CNT_W'(TMO_LAST));

  // Walking downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if ((bus.MST_PADDR & slv_mask[s]) == (slv_addr[s] & slv_mask[s])) begin
        hit     = 1'b1;
        hit_idx = SLV_W'(s);
      end
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    psel        = '0;
    prdata      = '0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup && hit) psel[hit_idx] = 1'b1;
      end
      ST_ACC: begin
        if (bus.MST_PSEL) begin
          psel[idx] = 1'b1;
          prdata    = bus.SLV_PRDATA[idx];
          pready    = bus.SLV_PREADY[idx];
          pslverr   = bus.SLV_PSLVERR[idx];
          // A late PREADY in the last allowed cycle still wins over the abort.
          if (!bus.SLV_PREADY[idx] && tmo_last) begin
            prdata      = '0;
            pready      = 1'b1;
            pslverr     = 1'b1;
            timeout_hit = 1'b1;
          end
        end
      end
      ST_ACC_DEF: begin
        if (bus.MST_PSEL) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.SLV_PSEL    = psel;
  assign bus.MST_PRDATA  = prdata;
  assign bus.MST_PREADY  = pready;
  assign bus.MST_PSLVERR = pslverr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_slv      <= '0;
    end else begin
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (setup) begin
            idx   <= hit_idx;
            state <= hit ? ST_ACC : ST_ACC_DEF;
          end
        end
        ST_ACC: begin
          if (!bus.MST_PSEL) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (pready) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (timeout_hit) begin
              err_timeout <= 1'b1;
              err_slv     <= idx;
            end
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACC_DEF: begin
          state <= ST_IDLE;
          cnt   <= '0;
          if (bus.MST_PSEL) err_unmapped <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mux_tmo.sv
// Self-checking bench for apb_mux_tmo: directed scenarios plus random transfers, all
// compared against a transfer-level model of the decode/timeout rules.
module tb_apb_mux_tmo;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NS  = 4;
  localparam int TMO = 4;
  localparam int SW  = 2;

  logic                   PCLK = 1'b0;
  logic                   PRESET = 1'b0;
  logic [NS-1:0][AW-1:0]  slv_addr;
  logic [NS-1:0][AW-1:0]  slv_mask;
  logic                   err_unmapped;
  logic                   err_timeout;
  logic [SW-1:0]          err_slv;

  int checks = 0;
  int errors = 0;

  int map_base [NS] = '{8'h00, 8'h40, 8'h80, 8'h80};
  int map_mask [NS] = '{8'hC0, 8'hC0, 8'hE0, 8'hC0};

  // Expected status outputs for the cycle currently being checked.
  bit exp_eu = 1'b0;
  bit exp_et = 1'b0;
  int exp_eslv = 0;

  apb_mux_tmo_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .SLAVES(NS)) bus ();

  apb_mux_tmo #(
    .PADDR_SIZE(AW), .PDATA_SIZE(DW), .SLAVES(NS), .TIMEOUT(TMO)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .bus          (bus),
    .slv_addr     (slv_addr),
    .slv_mask     (slv_mask),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout),
    .err_slv      (err_slv)
  );

  always #5 PCLK = ~PCLK;

  function automatic int ref_decode(input int a);
    for (int s = 0; s < NS; s++)
      if ((a & map_mask[s]) == (map_base[s] & map_mask[s])) return s;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic status_check(input string tag);
    check({tag, " err_unmapped"}, {31'd0, err_unmapped}, {31'd0, exp_eu});
    check({tag, " err_timeout"},  {31'd0, err_timeout},  {31'd0, exp_et});
    check({tag, " err_slv"},      {30'd0, err_slv},      exp_eslv);
    exp_eu = 1'b0;
    exp_et = 1'b0;
  endtask

  task automatic idle_cycle(input int n, input string tag);
    repeat (n) begin
      @(posedge PCLK); #1;
      bus.MST_PSEL    = 1'b0;
      bus.MST_PENABLE = 1'b0;
      bus.SLV_PREADY  = '0;
      bus.SLV_PSLVERR = '0;
      @(negedge PCLK);
      status_check(tag);
      check({tag, " idle psel"},   {28'd0, bus.SLV_PSEL}, 0);
      check({tag, " idle ready"},  {31'd0, bus.MST_PREADY}, 0);
      check({tag, " idle rdata"},  {24'd0, bus.MST_PRDATA}, 0);
    end
  endtask

  // One transfer: rdy_at = access cycle in which every slave raises PREADY (0 = never),
  // abort_at = access cycle after which the master drops PSEL (0 = never).
  task automatic xfer(input int addr, input int rdy_at, input bit serr,
                      input int abort_at, input string tag);
    int s;
    logic [NS-1:0] oh;
    s  = ref_decode(addr);
    oh = (s >= 0) ? NS'(1 << s) : '0;

    @(posedge PCLK); #1;
    bus.MST_PSEL    = 1'b1;
    bus.MST_PENABLE = 1'b0;
    bus.MST_PADDR   = AW'(addr);
    bus.SLV_PREADY  = '0;
    bus.SLV_PSLVERR = '0;
    @(negedge PCLK);
    status_check({tag, " setup"});
    check({tag, " setup psel"},  {28'd0, bus.SLV_PSEL}, {28'd0, oh});
    check({tag, " setup ready"}, {31'd0, bus.MST_PREADY}, 0);

    for (int k = 1; k <= 16; k++) begin
      logic [NS-1:0][DW-1:0] d;
      bit rdy;
      for (int j = 0; j < NS; j++) d[j] = DW'($urandom);
      rdy = (k == rdy_at);
      @(posedge PCLK); #1;
      bus.MST_PENABLE = 1'b1;
      bus.SLV_PRDATA  = d;
      bus.SLV_PREADY  = rdy ? '1 : '0;
      bus.SLV_PSLVERR = (rdy && serr) ? '1 : '0;
      @(negedge PCLK);
      status_check({tag, " access"});
      check({tag, " access psel"}, {28'd0, bus.SLV_PSEL}, {28'd0, oh});
      if (s < 0) begin
        check({tag, " unmapped ready"},  {31'd0, bus.MST_PREADY}, 1);
        check({tag, " unmapped slverr"}, {31'd0, bus.MST_PSLVERR}, 1);
        check({tag, " unmapped rdata"},  {24'd0, bus.MST_PRDATA}, 0);
        exp_eu = 1'b1;
        break;
      end else if (rdy) begin
        check({tag, " ready"},  {31'd0, bus.MST_PREADY}, 1);
        check({tag, " slverr"}, {31'd0, bus.MST_PSLVERR}, {31'd0, serr});
        check({tag, " rdata"},  {24'd0, bus.MST_PRDATA}, {24'd0, d[s]});
        break;
      end else if (k == TMO) begin
        check({tag, " abort ready"},  {31'd0, bus.MST_PREADY}, 1);
        check({tag, " abort slverr"}, {31'd0, bus.MST_PSLVERR}, 1);
        check({tag, " abort rdata"},  {24'd0, bus.MST_PRDATA}, 0);
        exp_et   = 1'b1;
        exp_eslv = s;
        break;
      end else begin
        check({tag, " wait ready"}, {31'd0, bus.MST_PREADY}, 0);
        if (k == abort_at) break;
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      slv_addr[s] = AW'(map_base[s]);
      slv_mask[s] = AW'(map_mask[s]);
    end
    bus.MST_PSEL    = 1'b0;
    bus.MST_PENABLE = 1'b0;
    bus.MST_PADDR   = '0;
    bus.SLV_PRDATA  = '0;
    bus.SLV_PREADY  = '0;
    bus.SLV_PSLVERR = '0;

    #1 PRESET = 1'b1;
    #11;
    status_check("reset");
    check("reset psel",  {28'd0, bus.SLV_PSEL}, 0);
    check("reset ready", {31'd0, bus.MST_PREADY}, 0);
    PRESET = 1'b0;
    idle_cycle(1, "post_reset");

    // Mapped read with zero wait states.
    xfer(8'h45, 1, 1'b0, 0, "s1_read");
    idle_cycle(1, "s1_gap");

    // Overlap resolves to the lower index, then back-to-back to the other slave.
    xfer(8'h90, 1, 1'b0, 0, "overlap_s2");
    xfer(8'hA0, 1, 1'b0, 0, "b2b_s3");
    idle_cycle(1, "b2b_gap");

    // Unmapped access answered by the default slave.
    xfer(8'hD0, 1, 1'b0, 0, "unmapped");
    idle_cycle(2, "unmapped_gap");

    // Timeout boundary: never ready aborts in cycle TMO; ready in cycle TMO completes.
    xfer(8'h10, 0, 1'b0, 0, "s0_timeout");
    idle_cycle(2, "timeout_gap");
    xfer(8'h10, TMO, 1'b0, 0, "s0_late_ready");
    idle_cycle(1, "late_gap");

    // Slave error passes through without a status pulse.
    xfer(8'h85, 2, 1'b1, 0, "s2_slverr");
    idle_cycle(2, "slverr_gap");

    // PENABLE without a setup is not a transfer.
    for (int i = 0; i < 2; i++) begin
      @(posedge PCLK); #1;
      bus.MST_PSEL    = 1'b1;
      bus.MST_PENABLE = 1'b1;
      bus.MST_PADDR   = 8'h45;
      bus.SLV_PREADY  = '1;
      @(negedge PCLK);
      status_check("no_setup");
      check("no_setup psel",  {28'd0, bus.SLV_PSEL}, 0);
      check("no_setup ready", {31'd0, bus.MST_PREADY}, 0);
    end

    // Master drops PSEL mid-access: silent return to idle.
    xfer(8'h05, 0, 1'b0, 1, "psel_drop");
    idle_cycle(2, "psel_drop_gap");

    // Leave err_slv non-zero, then reset in the middle of a wait-state transfer.
    xfer(8'h45, 0, 1'b0, 0, "s1_timeout");
    idle_cycle(1, "s1_timeout_gap");
    xfer(8'h45, 0, 1'b0, 2, "pre_reset");
    #1 PRESET = 1'b1;
    #1;
    check("midreset psel",     {28'd0, bus.SLV_PSEL}, 0);
    check("midreset ready",    {31'd0, bus.MST_PREADY}, 0);
    check("midreset unmapped", {31'd0, err_unmapped}, 0);
    check("midreset timeout",  {31'd0, err_timeout}, 0);
    check("midreset err_slv",  {30'd0, err_slv}, 0);
    #1 PRESET = 1'b0;
    exp_eslv = 0;
    exp_eu   = 1'b0;
    exp_et   = 1'b0;
    xfer(8'h45, 1, 1'b0, 0, "after_reset");

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      xfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
           1'($urandom_range(0, 1)), 0, "rand");
      if ($urandom_range(0, 1) == 1) idle_cycle(1, "rand_gap");
    end

    idle_cycle(2, "final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
